// File: rtl/nco_sequencer.sv
// -----------------------------------------------------------------------------
// nco_sequencer
//
// Dual-channel numerically controlled oscillator sequencer for a stereo DAC.
// Every rising edge of the DAC word clock (lrclk) starts a short, fixed
// sequence when enabled:
//   1. Both phase accumulators advance by their per-channel increments.
//   2. The left and then the right phase are turned into a quarter-wave ROM
//      address and read one after the other through a shared ROM port.
//   3. The ROM magnitudes are sign-corrected for the quadrant of their own
//      channel.
//   4. Both samples are presented together with a one-cycle sample_valid.
//
// Sequence timing, with E the cycle in which the synchronised edge is seen:
//   E+1 ACC    phases advance
//   E+2 RD_L   rom_en=1, left address
//   E+3 RD_R   rom_en=1, right address; left data captured
//   E+4 CAP_R  right data captured
//   E+5 DONE   samples registered; a deferred phase clear is applied here
//   E+6        left_sample/right_sample updated, sample_valid=1
//
// lrclk is asynchronous to clk and is brought in through a two-flop
// synchroniser followed by one more flop for rising-edge detection.
//
// Ports
//   clk           system clock (MCLK domain), single clock for all logic
//   reset_n       asynchronous active-low reset
//   lrclk         DAC word clock, asynchronous to clk
//   enable        when high, lrclk rising edges start sequences
//   phase_clr     single-cycle request to zero both accumulators
//   freq_l/r      per-channel phase increments (PHW bits), used in ACC
//   rom_en        quarter-wave ROM read strobe
//   rom_addr      quarter-wave ROM address (PW-2 bits), held when idle
//   rom_data      ROM read data, valid the cycle after rom_en
//   left_sample   signed two's-complement left sample (OW bits)
//   right_sample  signed two's-complement right sample (OW bits)
//   sample_valid  one-cycle pulse marking new samples
//   busy          a sequence is in progress
//   overrun       sticky: an edge arrived while busy and was dropped
// -----------------------------------------------------------------------------
module nco_sequencer #(
    parameter int PHW = 24,  // phase accumulator width
    parameter int PW  = 18,  // phase bits used for lookup (2 quadrant + PW-2 index)
    parameter int OW  = 24   // sample and ROM data width
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           lrclk,
    input  logic           enable,
    input  logic           phase_clr,
    input  logic [PHW-1:0] freq_l,
    input  logic [PHW-1:0] freq_r,
    output logic           rom_en,
    output logic [PW-3:0]  rom_addr,
    input  logic [OW-1:0]  rom_data,
    output logic [OW-1:0]  left_sample,
    output logic [OW-1:0]  right_sample,
    output logic           sample_valid,
    output logic           busy,
    output logic           overrun
);

    // -------------------------------------------------------------------------
    // FSM encoding
    // -------------------------------------------------------------------------
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ACC   = 3'd1;
    localparam logic [2:0] S_RD_L  = 3'd2;
    localparam logic [2:0] S_RD_R  = 3'd3;
    localparam logic [2:0] S_CAP_R = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]     state;
    logic [2:0]     next_state;

    // lrclk synchroniser and edge detector
    logic           lr_sync1;
    logic           lr_sync2;
    logic           lr_sync3;
    logic           lr_rise;

    // Phase accumulators and their lookup words
    logic [PHW-1:0] phase_l;
    logic [PHW-1:0] phase_r;
    logic [PHW-1:0] phase_l_next;
    logic [PW-1:0]  look_l;
    logic [PW-1:0]  look_r;
    logic [PW-3:0]  addr_l;
    logic [PW-3:0]  addr_r;

    // Per-channel negate flags (quadrant MSB) and captured samples
    logic           neg_l;
    logic           neg_r;
    logic [OW-1:0]  cap_l;
    logic [OW-1:0]  cap_r;

    // Phase clear requested while busy, applied when the sequence ends
    logic           clr_pending;

    // Two's-complement negation of a ROM magnitude for the lower half-wave.
    function automatic logic [OW-1:0] apply_sign(input logic [OW-1:0] mag,
                                                 input logic          neg);
        return neg ? (~mag + OW'(1)) : mag;
    endfunction

    // -------------------------------------------------------------------------
    // lrclk synchroniser: two metastability flops plus one edge-detect flop
    // -------------------------------------------------------------------------
    // NOTE: every clocked block uses non-blocking assignments so all flops
    // sample their inputs from the same edge, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lr_sync1 <= 1'b0;
            lr_sync2 <= 1'b0;
            lr_sync3 <= 1'b0;
        end else begin
            lr_sync1 <= lrclk;
            lr_sync2 <= lr_sync1;
            lr_sync3 <= lr_sync2;
        end
    end

    assign lr_rise = lr_sync2 & ~lr_sync3;

    // -------------------------------------------------------------------------
    // Sequencer FSM: one state per cycle, no early exits
    // -------------------------------------------------------------------------
    // NOTE: next_state gets a default before the case so no path through the
    // block leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = S_IDLE;
        case (state)
            // A clear request coincident with an edge wins: the edge is
            // dropped and only the accumulators are zeroed.
            S_IDLE:  next_state = (lr_rise && enable && !phase_clr) ? S_ACC : S_IDLE;
            S_ACC:   next_state = S_RD_L;
            S_RD_L:  next_state = S_RD_R;
            S_RD_R:  next_state = S_CAP_R;
            S_CAP_R: next_state = S_DONE;
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    assign busy = (state != S_IDLE);

    // Edges are never queued; one that lands mid-sequence is only recorded.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun <= 1'b0;
        end else if (lr_rise && busy) begin
            overrun <= 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Phase accumulators
    // -------------------------------------------------------------------------
    assign phase_l_next = phase_l + freq_l;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_l     <= '0;
            phase_r     <= '0;
            clr_pending <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (phase_clr) begin
                        phase_l <= '0;
                        phase_r <= '0;
                    end
                end
                S_ACC: begin
                    // Silent modulo-2^PHW wrap from the natural adder width.
                    phase_l <= phase_l_next;
                    phase_r <= phase_r + freq_r;
                end
                S_DONE: begin
                    // A request arriving in DONE itself is honoured here too.
                    if (clr_pending || phase_clr) begin
                        phase_l <= '0;
                        phase_r <= '0;
                    end
                end
                default: begin
                end
            endcase

            if (state == S_DONE) begin
                clr_pending <= 1'b0;
            end else if (busy && phase_clr) begin
                clr_pending <= 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Quarter-wave address mapping
    // The left address is issued on the ACC->RD_L edge, so it is taken from
    // the value the accumulator is being loaded with. The right address is
    // issued one cycle later, from the already updated accumulator.
    // -------------------------------------------------------------------------
    assign look_l = phase_l_next[PHW-1 -: PW];
    assign look_r = phase_r[PHW-1 -: PW];

    // Odd quadrants walk the quarter wave backwards.
    assign addr_l = look_l[PW-2] ? ~look_l[PW-3:0] : look_l[PW-3:0];
    assign addr_r = look_r[PW-2] ? ~look_r[PW-3:0] : look_r[PW-3:0];

    // -------------------------------------------------------------------------
    // ROM port, data capture and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rom_en       <= 1'b0;
            rom_addr     <= '0;
            neg_l        <= 1'b0;
            neg_r        <= 1'b0;
            cap_l        <= '0;
            cap_r        <= '0;
            left_sample  <= '0;
            right_sample <= '0;
            sample_valid <= 1'b0;
        end else begin
            rom_en       <= 1'b0;
            sample_valid <= 1'b0;
            case (state)
                S_ACC: begin
                    // Strobe is high during RD_L with the left address.
                    rom_en   <= 1'b1;
                    rom_addr <= addr_l;
                    neg_l    <= look_l[PW-1];
                end
                S_RD_L: begin
                    // Strobe is high during RD_R with the right address.
                    rom_en   <= 1'b1;
                    rom_addr <= addr_r;
                    neg_r    <= look_r[PW-1];
                end
                S_RD_R: begin
                    cap_l <= apply_sign(rom_data, neg_l);
                end
                S_CAP_R: begin
                    cap_r <= apply_sign(rom_data, neg_r);
                end
                S_DONE: begin
                    left_sample  <= cap_l;
                    right_sample <= cap_r;
                    sample_valid <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nco_sequencer.sv
// -----------------------------------------------------------------------------
// tb_nco_sequencer
//
// Self-checking bench for nco_sequencer. A behavioural model tracks both
// phases as plain integers and derives the expected ROM addresses and
// samples from the quarter-wave rules with ordinary arithmetic. Each call of
// run_seq produces one lrclk rising edge and checks the whole sequence
// cycle by cycle, relative to the cycle E in which the edge is detected.
// -----------------------------------------------------------------------------
module tb_nco_sequencer;

    localparam int PHW  = 24;
    localparam int PW   = 18;
    localparam int OW   = 24;
    localparam int NONE = -100;
    localparam int unsigned PH_MASK = (32'd1 << PHW) - 32'd1;

    logic           clk = 1'b0;
    logic           reset_n = 1'b1;
    logic           lrclk = 1'b0;
    logic           enable = 1'b0;
    logic           phase_clr = 1'b0;
    logic [PHW-1:0] freq_l = '0;
    logic [PHW-1:0] freq_r = '0;
    logic           rom_en;
    logic [PW-3:0]  rom_addr;
    logic [OW-1:0]  rom_data = '0;
    logic [OW-1:0]  left_sample;
    logic [OW-1:0]  right_sample;
    logic           sample_valid;
    logic           busy;
    logic           overrun;

    int checks   = 0;
    int failures = 0;

    // ROM content selector: 0 = {8'h0, addr}, 1 = scrambled positive values
    bit rom_mode = 1'b0;

    // Reference model state
    int unsigned   m_ph_l = 0;
    int unsigned   m_ph_r = 0;
    logic [OW-1:0] m_left = '0;
    logic [OW-1:0] m_right = '0;
    bit            m_overrun = 1'b0;

    // Last observed left address / left sample of the most recent sequence
    logic [PW-3:0] obs_addr_l = '0;
    logic [OW-1:0] obs_left = '0;

    nco_sequencer #(.PHW(PHW), .PW(PW), .OW(OW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .lrclk        (lrclk),
        .enable       (enable),
        .phase_clr    (phase_clr),
        .freq_l       (freq_l),
        .freq_r       (freq_r),
        .rom_en       (rom_en),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .left_sample  (left_sample),
        .right_sample (right_sample),
        .sample_valid (sample_valid),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    // Quarter-wave ROM contents, always below 2^(OW-1).
    function automatic logic [OW-1:0] rom_f(input logic [PW-3:0] a);
        logic [OW-1:0] t;
        if (rom_mode == 1'b0) return {8'h00, a};
        t = {8'h00, a} * 24'h009E37 + 24'h001234;
        return {1'b0, t[OW-2:0]};
    endfunction

    // Synchronous-read ROM: data is valid the cycle after the strobe.
    always @(posedge clk) begin
        if (rom_en) rom_data <= rom_f(rom_addr);
    end

    // Model: which quarter-wave entry a phase maps to.
    function automatic logic [PW-3:0] m_addr(input int unsigned ph);
        int unsigned quadrant;
        int unsigned idx;
        int unsigned span;
        span     = 32'd1 << (PW - 2);
        quadrant = ph >> (PHW - 2);
        idx      = (ph >> (PHW - PW)) % span;
        if (quadrant % 2 == 1) return (PW-2)'(span - 1 - idx);
        return (PW-2)'(idx);
    endfunction

    // Model: signed sample for a phase (negative half in quadrants 2 and 3).
    function automatic logic [OW-1:0] m_sample(input int unsigned ph);
        int unsigned quadrant;
        longint      v;
        longint      full;
        quadrant = ph >> (PHW - 2);
        v        = longint'(rom_f(m_addr(ph)));
        full     = longint'(1) << OW;
        if (quadrant >= 2) return OW'((full - v) % full);
        return OW'(v);
    endfunction

    // -------------------------------------------------------------------------
    // One lrclk edge and the full observation window around it.
    // Step c observes cycle E+c at the falling edge, then drives inputs for
    // cycle E+c. An lrclk rise driven at step k is detected at step k+2.
    // -------------------------------------------------------------------------
    task automatic run_seq(input logic [PHW-1:0] fl, input logic [PHW-1:0] fr,
                           input int clr_at, input int glitch_at,
                           input int rst_at, input int en_off_at, input bit en);
        bit            active;
        bit            rst_done;
        bit            exp_en;
        bit            exp_busy;
        bit            exp_valid;
        logic [PW-3:0] e_addr_l;
        logic [PW-3:0] e_addr_r;
        logic [OW-1:0] e_left;
        logic [OW-1:0] e_right;
        logic [OW-1:0] x_left;
        logic [OW-1:0] x_right;

        freq_l   = fl;
        freq_r   = fr;
        enable   = en;
        rst_done = 1'b0;
        e_addr_l = '0;
        e_addr_r = '0;
        e_left   = '0;
        e_right  = '0;

        active = en && (clr_at != 0) && (en_off_at == NONE || en_off_at > 0);
        if (clr_at == -1 || clr_at == 0) begin
            m_ph_l = 0;
            m_ph_r = 0;
        end
        if (active) begin
            m_ph_l   = (m_ph_l + 32'(fl)) & PH_MASK;
            m_ph_r   = (m_ph_r + 32'(fr)) & PH_MASK;
            e_addr_l = m_addr(m_ph_l);
            e_addr_r = m_addr(m_ph_r);
            e_left   = m_sample(m_ph_l);
            e_right  = m_sample(m_ph_r);
            if (glitch_at >= 1 && glitch_at <= 5) m_overrun = 1'b1;
        end

        for (int c = -2; c <= 8; c++) begin
            @(negedge clk);
            if (!rst_done && c >= -1) begin
                exp_en    = active && (c == 2 || c == 3);
                exp_busy  = active && (c >= 1 && c <= 5);
                exp_valid = active && (c == 6);
                x_left    = (active && c >= 6) ? e_left : m_left;
                x_right   = (active && c >= 6) ? e_right : m_right;

                checks++;
                if (rom_en !== exp_en) begin
                    failures++;
                    $display("FAIL rom_en E+%0d: got %0b expected %0b", c, rom_en, exp_en);
                end
                if (exp_en) begin
                    checks++;
                    if (rom_addr !== (c == 2 ? e_addr_l : e_addr_r)) begin
                        failures++;
                        $display("FAIL rom_addr E+%0d: got %h expected %h", c, rom_addr,
                                 (c == 2 ? e_addr_l : e_addr_r));
                    end
                    if (c == 2) obs_addr_l = rom_addr;
                end
                checks++;
                if (busy !== exp_busy) begin
                    failures++;
                    $display("FAIL busy E+%0d: got %0b expected %0b", c, busy, exp_busy);
                end
                checks++;
                if (sample_valid !== exp_valid) begin
                    failures++;
                    $display("FAIL sample_valid E+%0d: got %0b expected %0b", c, sample_valid, exp_valid);
                end
                checks++;
                if (left_sample !== x_left || right_sample !== x_right) begin
                    failures++;
                    $display("FAIL samples E+%0d: got %h/%h expected %h/%h", c,
                             left_sample, right_sample, x_left, x_right);
                end
                if (c == 6) obs_left = left_sample;
            end else if (rst_done) begin
                checks++;
                if (sample_valid !== 1'b0 || busy !== 1'b0) begin
                    failures++;
                    $display("FAIL in_reset E+%0d: got valid=%0b busy=%0b expected 0/0", c, sample_valid, busy);
                end
            end

            lrclk     = (c == -2) || (glitch_at != NONE && c == glitch_at - 2);
            phase_clr = (c == clr_at);
            if (c == en_off_at) enable = 1'b0;
            if (c == rst_at) begin
                reset_n = 1'b0;
                #1;
                checks++;
                if (rom_en !== 1'b0 || busy !== 1'b0 || sample_valid !== 1'b0 ||
                    left_sample !== '0 || right_sample !== '0 || overrun !== 1'b0) begin
                    failures++;
                    $display("FAIL async_reset: got en=%0b busy=%0b valid=%0b l=%h r=%h ovr=%0b expected all 0",
                             rom_en, busy, sample_valid, left_sample, right_sample, overrun);
                end
                rst_done = 1'b1;
            end
        end

        @(negedge clk);
        lrclk     = 1'b0;
        phase_clr = 1'b0;
        enable    = 1'b1;

        if (rst_done) begin
            m_ph_l    = 0;
            m_ph_r    = 0;
            m_left    = '0;
            m_right   = '0;
            m_overrun = 1'b0;
            repeat (3) @(negedge clk);
            reset_n = 1'b1;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                checks++;
                if (sample_valid !== 1'b0 || busy !== 1'b0) begin
                    failures++;
                    $display("FAIL after_reset cycle %0d: got valid=%0b busy=%0b expected 0/0",
                             i, sample_valid, busy);
                end
            end
        end else begin
            if (active) begin
                m_left  = e_left;
                m_right = e_right;
            end
            if (clr_at >= 1) begin
                m_ph_l = 0;
                m_ph_r = 0;
            end
        end

        checks++;
        if (left_sample !== m_left || right_sample !== m_right || overrun !== m_overrun) begin
            failures++;
            $display("FAIL hold: got %h/%h ovr=%0b expected %h/%h ovr=%0b",
                     left_sample, right_sample, overrun, m_left, m_right, m_overrun);
        end
        repeat (3) @(negedge clk);
    endtask

    // -------------------------------------------------------------------------
    // Scenarios
    // -------------------------------------------------------------------------
    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (rom_en !== 1'b0 || rom_addr !== '0 || left_sample !== '0 || right_sample !== '0 ||
            sample_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: got en=%0b addr=%h l=%h r=%h valid=%0b busy=%0b ovr=%0b expected all 0",
                     rom_en, rom_addr, left_sample, right_sample, sample_valid, busy, overrun);
        end
        reset_n = 1'b1;
        enable  = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || sample_valid !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_idle: got busy=%0b valid=%0b expected 0/0", busy, sample_valid);
        end
    endtask

    task automatic test_quadrant_walk();
        logic [PW-3:0] want_addr [4];
        logic [OW-1:0] want_left [4];
        want_addr[0] = 16'hFFFF; want_left[0] = 24'h00FFFF;
        want_addr[1] = 16'h0000; want_left[1] = 24'h000000;
        want_addr[2] = 16'hFFFF; want_left[2] = 24'hFF0001;
        want_addr[3] = 16'h0000; want_left[3] = 24'h000000;
        rom_mode = 1'b0;
        for (int i = 0; i < 4; i++) begin
            run_seq(24'h400000, PHW'($urandom()), NONE, NONE, NONE, NONE, 1'b1);
            checks++;
            if (obs_addr_l !== want_addr[i] || obs_left !== want_left[i]) begin
                failures++;
                $display("FAIL quadrant_walk %0d: got addr=%h left=%h expected addr=%h left=%h",
                         i, obs_addr_l, obs_left, want_addr[i], want_left[i]);
            end
        end
    endtask

    task automatic test_single_edge();
        rom_mode = 1'b0;
        // Clear in IDLE just before the edge so the phase becomes 174763.
        run_seq(24'd174763, 24'd174763, -1, NONE, NONE, NONE, 1'b1);
        checks++;
        if (obs_addr_l !== 16'h0AAA || obs_left !== 24'h000AAA) begin
            failures++;
            $display("FAIL single_edge: got addr=%h left=%h expected addr=0aaa left=000aaa",
                     obs_addr_l, obs_left);
        end
    endtask

    task automatic test_enable();
        rom_mode = 1'b1;
        run_seq(PHW'($urandom()), PHW'($urandom()), NONE, NONE, NONE, NONE, 1'b0);
        run_seq(PHW'($urandom()), PHW'($urandom()), NONE, NONE, NONE, 2, 1'b1);
    endtask

    task automatic test_phase_clr();
        rom_mode = 1'b1;
        run_seq(PHW'($urandom()), PHW'($urandom()), NONE, NONE, NONE, NONE, 1'b1);
        run_seq(PHW'($urandom()), PHW'($urandom()), 2, NONE, NONE, NONE, 1'b1);
        run_seq(24'h123457, 24'h0FEDCB, NONE, NONE, NONE, NONE, 1'b1);
        // Clear coincident with the edge: edge dropped, overrun untouched.
        run_seq(PHW'($urandom()), PHW'($urandom()), 0, NONE, NONE, NONE, 1'b1);
        run_seq(PHW'($urandom()), PHW'($urandom()), NONE, NONE, NONE, NONE, 1'b1);
    endtask

    task automatic test_overrun();
        rom_mode = 1'b1;
        run_seq(PHW'($urandom()), PHW'($urandom()), NONE, 3, NONE, NONE, 1'b1);
        run_seq(PHW'($urandom()), PHW'($urandom()), NONE, NONE, NONE, NONE, 1'b1);
        run_seq(PHW'($urandom()), PHW'($urandom()), NONE, NONE, NONE, NONE, 1'b1);
    endtask

    task automatic test_wrap();
        rom_mode = 1'b1;
        run_seq(24'h000001, 24'h000000, -1, NONE, NONE, NONE, 1'b1);
        run_seq(24'hFFFFFF, 24'h000000, NONE, NONE, NONE, NONE, 1'b1);
        checks++;
        if (obs_addr_l !== 16'h0000 || obs_left !== 24'h001234) begin
            failures++;
            $display("FAIL wrap: got addr=%h left=%h expected addr=0000 left=001234",
                     obs_addr_l, obs_left);
        end
    endtask

    task automatic test_reset_mid();
        rom_mode = 1'b1;
        run_seq(PHW'($urandom()), PHW'($urandom()), NONE, NONE, 3, NONE, 1'b1);
        run_seq(PHW'($urandom()), PHW'($urandom()), NONE, NONE, NONE, NONE, 1'b1);
    endtask

    task automatic test_back_to_back();
        int sel;
        int clr;
        rom_mode = 1'b1;
        for (int i = 0; i < 16; i++) begin
            sel = int'($urandom_range(0, 3));
            clr = (sel == 0) ? -1 : (sel == 1) ? 2 : NONE;
            run_seq(PHW'($urandom()), PHW'($urandom()), clr, NONE, NONE, NONE, 1'b1);
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_quadrant_walk();
        test_single_edge();
        test_enable();
        test_phase_clr();
        test_overrun();
        test_wrap();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nco_sequencer.md
NCO_SEQUENCER -- requirements
Module: nco_sequencer

Interface
REQ-001 SHALL have parameter PHW, default 24, meaning phase accumulator width.
REQ-002 SHALL have parameter PW, default 18, meaning phase bits used for lookup (2 quadrant + PW-2 index).
REQ-003 SHALL have parameter OW, default 24, meaning sample and ROM data width.
REQ-004 SHALL have port clk  in  1  system clock (MCLK domain, 49.152 MHz); single clock for all logic.
REQ-005 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port lrclk  in  1  DAC word clock, asynchronous to clk.
REQ-007 SHALL have port enable  in  1  when high, lrclk rising edges start sequences.
REQ-008 SHALL have port phase_clr  in  1  single-cycle request to zero both accumulators.
REQ-009 SHALL have port freq_l, freq_r  in  PHW each  per-channel phase increments, sampled in ACC.
REQ-010 SHALL have port rom_en  out  1  quarter-wave ROM read strobe.
REQ-011 SHALL have port rom_addr  out  PW-2  quarter-wave ROM address.
REQ-012 SHALL have port rom_data  in  OW  ROM data, valid the cycle after rom_en.
REQ-013 SHALL have port left_sample, right_sample  out  OW each  signed two's-complement samples.
REQ-014 SHALL have port sample_valid  out  1  one-cycle pulse marking new samples.
REQ-015 SHALL have ports busy (out, 1, sequence in progress) and overrun (out, 1, sticky missed-edge flag).

Function
REQ-016 SHALL pass lrclk through a 2-flop synchronizer plus a third edge-detect flop; a rising edge is registered in cycle E.
REQ-017 SHALL use FSM states IDLE, ACC, RD_L, RD_R, CAP_R, DONE, advancing one state per cycle, with DONE returning to IDLE.
REQ-018 SHALL leave IDLE only when an edge is detected in IDLE with enable=1; otherwise it SHALL remain in IDLE.
REQ-019 ACC (E+1) SHALL update phase_l += freq_l and phase_r += freq_r, modulo 2^PHW with silent wrap.
REQ-020 Lookup word SHALL be p = phase[PHW-1 -: PW]; quadrant q = p[PW-1:PW-2]; idx = p[PW-3:0].
REQ-021 rom_addr SHALL be idx when q[0]=0 and ~idx when q[0]=1.
REQ-022 RD_L (E+2) SHALL assert rom_en with the left address; RD_R (E+3) SHALL capture left rom_data and assert rom_en with the right address; CAP_R (E+4) SHALL capture right rom_data.
REQ-023 rom_en SHALL be low in every other state; rom_addr SHALL hold its last value when rom_en is low.
REQ-024 Captured data SHALL be negated in two's complement when q[1]=1 (ROM holds non-negative values < 2^(OW-1)), using the q of the same channel.
REQ-025 DONE (E+5) SHALL register both samples; outputs and sample_valid=1 SHALL appear together in cycle E+6, for exactly one cycle.
REQ-026 busy SHALL be high in all states other than IDLE.
REQ-027 An edge detected while busy SHALL be dropped, not queued, and SHALL set overrun; overrun SHALL clear only on reset.
REQ-028 phase_clr in IDLE SHALL zero both accumulators on the next clock; phase_clr while busy SHALL be latched and applied on the DONE->IDLE transition.
REQ-029 phase_clr coincident with an edge in IDLE SHALL take priority: accumulators cleared, edge dropped, overrun unchanged.
REQ-030 enable low SHALL hold the phases and outputs; deasserting enable mid-sequence SHALL NOT abort the sequence in progress.

Reset
REQ-031 While reset_n=0 the block SHALL force: state IDLE; phases 0; synchronizer flops 0; rom_en 0; rom_addr 0; left_sample, right_sample 0; sample_valid, busy, overrun 0; pending clear 0.
REQ-032 Reset assertion mid-sequence SHALL abort immediately with no sample_valid; after release, the first edge SHALL require a fresh 0->1 lrclk transition seen by the synchronizer.

Verification
REQ-033 freq_l=0x400000 with a ROM model returning {8'h0, addr}, over 4 edges -> left rom_addr 0xFFFF, 0x0000, 0xFFFF, 0x0000; left_sample +0x00FFFF, -0x000000 (=0), -0x00FFFF (0xFF0001), +0x000000.
REQ-034 Single edge, freq_l=freq_r=174763 -> rom_en high exactly at E+2 and E+3, sample_valid high only at E+6, phase_l=174763.
REQ-035 Second lrclk edge injected at E+3 -> no second sequence, overrun=1 and stays 1 through later normal edges.
REQ-036 phase_clr pulsed at E+2 -> current samples still computed from the pre-clear phase; the next edge produces phase=freq.
REQ-037 reset_n low at E+3 -> rom_en=0, busy=0, outputs 0 asynchronously; no sample_valid until a new edge after release.
REQ-038 freq_l=0xFFFFFF starting from phase 0x000001 -> phase wraps to 0x000000; sample equals the ROM value at addr 0, positive.
